// File: rtl/comparator_stim_gen.sv
//------------------------------------------------------------------------------
// Module      : comparator_stim_gen
// Description : Self-test engine for a magnitude comparator. Drives a/b vectors
//               (exhaustive or LFSR), checks the three flags, and keeps pass/fail
//               counts plus the first failing vector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module comparator_stim_gen #(
    parameter int          WIDTH     = 1,
    parameter int          MODE      = 0,
    parameter int          NUM_RAND  = 16,
    parameter int          SETTLE    = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             a_equal_b,
    input  logic             a_less_b,
    input  logic             a_greater_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic             fail_seen
);

    localparam logic [15:0] c_seed        = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] c_lfsr_taps   = 16'hB400;
    localparam logic [15:0] c_src_init    = (MODE == 0) ? 16'h0000 : c_seed;
    localparam logic [16:0] c_num_vec     = (MODE == 0) ? (17'd1 << (2 * WIDTH)) : 17'(NUM_RAND);
    localparam logic [16:0] c_last_vec    = c_num_vec - 17'd1;
    localparam logic [3:0]  c_settle_last = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_settle_cnt;
    logic [15:0]        r_src;
    logic [16:0]        r_vec_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [15:0]        r_pass_cnt;
    logic [15:0]        r_fail_cnt;
    logic [WIDTH-1:0]   r_ffa;
    logic [WIDTH-1:0]   r_ffb;
    logic               r_fail_seen;

    logic [15:0]        w_src_next;
    logic [2*WIDTH-1:0] w_load_src;
    logic [2:0]         w_exp;
    logic [2:0]         w_flags;
    logic               w_mismatch;
    logic               w_last_vec;
    logic               w_start_run;

    // r_src is the vector source: a plain index or the LFSR state.
    generate
        if (MODE == 0) begin : g_exhaustive
            assign w_src_next = r_src + 16'd1;
        end else begin : g_lfsr
            assign w_src_next = {1'b0, r_src[15:1]} ^ (r_src[0] ? c_lfsr_taps : 16'h0000);
        end
    endgenerate

    // The first vector of a run comes from the init value, later ones from the step.
    assign w_load_src  = (r_state == S_CHECK) ? w_src_next[2*WIDTH-1:0] : c_src_init[2*WIDTH-1:0];
    assign w_exp       = {(r_a == r_b), (r_a < r_b), (r_a > r_b)};
    assign w_flags     = {a_equal_b, a_less_b, a_greater_b};
    assign w_mismatch  = (w_flags != w_exp);
    assign w_last_vec  = (r_vec_idx == c_last_vec);
    assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_DRIVE;
            end
            S_DRIVE: begin
                busy         = 1'b1;
                w_state_next = (SETTLE == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (r_settle_cnt == c_settle_last) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                busy         = 1'b1;
                err          = w_mismatch;
                w_state_next = w_last_vec ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_next = S_DRIVE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= 4'd0;
            r_src        <= c_src_init;
            r_vec_idx    <= 17'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_pass_cnt   <= 16'd0;
            r_fail_cnt   <= 16'd0;
            r_ffa        <= '0;
            r_ffb        <= '0;
            r_fail_seen  <= 1'b0;
        end else if (w_start_run) begin
            r_settle_cnt <= 4'd0;
            r_src        <= c_src_init;
            r_vec_idx    <= 17'd0;
            r_a          <= w_load_src[2*WIDTH-1:WIDTH];
            r_b          <= w_load_src[WIDTH-1:0];
            r_pass_cnt   <= 16'd0;
            r_fail_cnt   <= 16'd0;
            r_ffa        <= '0;
            r_ffb        <= '0;
            r_fail_seen  <= 1'b0;
        end else begin
            case (r_state)
                S_DRIVE:  r_settle_cnt <= 4'd0;
                S_SETTLE: r_settle_cnt <= r_settle_cnt + 4'd1;
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_fail_cnt != 16'hFFFF) r_fail_cnt <= r_fail_cnt + 16'd1;
                        if (!r_fail_seen) begin
                            r_ffa       <= r_a;
                            r_ffb       <= r_b;
                            r_fail_seen <= 1'b1;
                        end
                    end else if (r_pass_cnt != 16'hFFFF) begin
                        r_pass_cnt <= r_pass_cnt + 16'd1;
                    end
                    // The next vector lands on the same edge that leaves CHECK.
                    if (!w_last_vec) begin
                        r_src     <= w_src_next;
                        r_vec_idx <= r_vec_idx + 17'd1;
                        r_a       <= w_load_src[2*WIDTH-1:WIDTH];
                        r_b       <= w_load_src[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign a            = r_a;
    assign b            = r_b;
    assign pass_cnt     = r_pass_cnt;
    assign fail_cnt     = r_fail_cnt;
    assign first_fail_a = r_ffa;
    assign first_fail_b = r_ffb;
    assign fail_seen    = r_fail_seen;

endmodule

`default_nettype wire

// File: tb/tb_comparator_stim_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_comparator_stim_gen
// Description : Three engine configurations against a behavioural comparator
//               with selectable faults, checked by a run-timeline model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_comparator_stim_gen;

    localparam int NK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0;
    always #5 clk = ~clk;

    int          fault [NK];
    logic [15:0] key   [NK];
    logic [2:0]  flags [NK];
    logic [7:0]  a_o [NK], b_o [NK], ffa_o [NK], ffb_o [NK];
    logic        busy_o [NK], done_o [NK], err_o [NK], fs_o [NK];
    logic [15:0] pass_o [NK], fail_o [NK];
    logic [15:0] lfsr_tab [16];

    logic [0:0] a0, b0, fa0, fb0;
    logic [3:0] a1, b1, fa1, fb1;
    logic [1:0] a2, b2, fa2, fb2;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en = 1'b0;
    bit  act [NK];
    int  d   [NK];
    int  mf  [NK];
    logic [15:0] mk [NK];

    function automatic int p_w(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 2;
    endfunction
    function automatic int p_s(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 2;
    endfunction
    function automatic int p_v(input int k);
        return (k == 2) ? 16 : (1 << (2 * p_w(k)));
    endfunction

    function automatic logic [2:0] dut_flags(input int f, input logic [7:0] x, input logic [7:0] y,
                                             input logic [15:0] kk, input int w);
        logic [2:0] r;
        r = {x == y, x < y, x > y};
        case (f)
            1: r[1] = 1'b0;
            2: r = 3'b111;
            3: if (((16'(x) << w) | 16'(y)) == kk) r[2] = ~r[2];
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] vec(input int k, input int v);
        return (k == 2) ? lfsr_tab[v] : 16'(v);
    endfunction
    function automatic logic [7:0] va(input int k, input int v);
        return 8'((vec(k, v) >> p_w(k)) & 16'((1 << p_w(k)) - 1));
    endfunction
    function automatic logic [7:0] vb(input int k, input int v);
        return 8'(vec(k, v) & 16'((1 << p_w(k)) - 1));
    endfunction
    function automatic bit vfail(input int k, input int v);
        logic [7:0] x, y;
        x = va(k, v);
        y = vb(k, v);
        return dut_flags(mf[k], x, y, mk[k], p_w(k)) != {x == y, x < y, x > y};
    endfunction

    always_comb begin
        a_o[0] = 8'(a0);  b_o[0] = 8'(b0);  ffa_o[0] = 8'(fa0); ffb_o[0] = 8'(fb0);
        a_o[1] = 8'(a1);  b_o[1] = 8'(b1);  ffa_o[1] = 8'(fa1); ffb_o[1] = 8'(fb1);
        a_o[2] = 8'(a2);  b_o[2] = 8'(b2);  ffa_o[2] = 8'(fa2); ffb_o[2] = 8'(fb2);
        for (int k = 0; k < NK; k++) flags[k] = dut_flags(fault[k], a_o[k], b_o[k], key[k], p_w(k));
    end

    comparator_stim_gen #(.WIDTH(1), .MODE(0), .NUM_RAND(16), .SETTLE(1), .LFSR_SEED(16'hACE1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a0), .b(b0),
        .a_equal_b(flags[0][2]), .a_less_b(flags[0][1]), .a_greater_b(flags[0][0]),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .pass_cnt(pass_o[0]), .fail_cnt(fail_o[0]),
        .first_fail_a(fa0), .first_fail_b(fb0), .fail_seen(fs_o[0]));

    comparator_stim_gen #(.WIDTH(4), .MODE(0), .NUM_RAND(16), .SETTLE(0), .LFSR_SEED(16'hACE1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a1), .b(b1),
        .a_equal_b(flags[1][2]), .a_less_b(flags[1][1]), .a_greater_b(flags[1][0]),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .pass_cnt(pass_o[1]), .fail_cnt(fail_o[1]),
        .first_fail_a(fa1), .first_fail_b(fb1), .fail_seen(fs_o[1]));

    comparator_stim_gen #(.WIDTH(2), .MODE(1), .NUM_RAND(16), .SETTLE(2), .LFSR_SEED(16'hACE1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a2), .b(b2),
        .a_equal_b(flags[2][2]), .a_less_b(flags[2][1]), .a_greater_b(flags[2][0]),
        .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2]), .pass_cnt(pass_o[2]), .fail_cnt(fail_o[2]),
        .first_fail_a(fa2), .first_fail_b(fb2), .fail_seen(fs_o[2]));

    // Model: d = cycles since the start edge; everything derives from that timeline.
    always @(posedge clk) begin
        if (rst) chk_en = 1'b1;
        for (int k = 0; k < NK; k++) begin
            int lim;
            lim = p_v(k) * (2 + p_s(k));
            if (rst) begin
                act[k] = 1'b0;
                d[k]   = 0;
            end else if (start[k] && (!act[k] || d[k] > lim)) begin
                act[k] = 1'b1;
                d[k]   = 1;
                mf[k]  = fault[k];
                mk[k]  = key[k];
            end else if (act[k] && d[k] <= lim) begin
                d[k]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NK; k++) begin
                logic [67:0] exp_v, act_v;
                int P, V, v, nchk, pc, fc;
                bit run, e_err, fs;
                logic [7:0] fx, fy;
                P = 2 + p_s(k);
                V = p_v(k);
                exp_v = '0;
                if (act[k]) begin
                    run  = (d[k] <= V * P);
                    v    = run ? (d[k] - 1) / P : V - 1;
                    nchk = (d[k] - 1) / P;
                    pc = 0; fc = 0; fs = 1'b0; fx = 8'd0; fy = 8'd0;
                    for (int j = 0; j < nchk; j++) begin
                        if (vfail(k, j)) begin
                            fc++;
                            if (!fs) begin fs = 1'b1; fx = va(k, j); fy = vb(k, j); end
                        end else begin
                            pc++;
                        end
                    end
                    e_err = run && ((d[k] - 1) % P == P - 1) && vfail(k, v);
                    exp_v = {va(k, v), vb(k, v), run, !run, e_err, 16'(pc), 16'(fc), fx, fy, fs};
                end
                act_v = {a_o[k], b_o[k], busy_o[k], done_o[k], err_o[k], pass_o[k], fail_o[k],
                         ffa_o[k], ffb_o[k], fs_o[k]};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_errors++;
                    $display("FAIL cycle_model k=%0d t=%0t actual=%h expected=%h", k, $time, act_v, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic run_k(input int k, input int f, output int ncyc, output int nerr);
        fault[k] = f;
        start[k] = 1'b1;
        ncyc = 0;
        nerr = 0;
        do begin
            @(posedge clk); #2;
            ncyc++;
            if (err_o[k]) nerr++;
            start[k] = busy_o[k] && ($urandom_range(0, 3) == 0);
        end while (!done_o[k] && ncyc < 4000);
        start[k] = 1'b0;
        if (ncyc >= 4000) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout k=%0d actual=%0d cycles required=done", k, ncyc);
        end
    endtask

    initial begin
        int nc, ne, cnt;
        for (int k = 0; k < NK; k++) begin fault[k] = 0; key[k] = 16'h0; act[k] = 1'b0; d[k] = 0; mf[k] = 0; mk[k] = 16'h0; end
        lfsr_tab[0] = 16'hACE1;
        for (int i = 1; i < 16; i++)
            lfsr_tab[i] = (lfsr_tab[i-1] >> 1) ^ (lfsr_tab[i-1][0] ? 16'hB400 : 16'h0000);
        check("model_lfsr1", int'(lfsr_tab[1]), 32'hE270);
        check("model_lfsr2", int'(lfsr_tab[2]), 32'h7138);
        check("model_vec0_b", int'(vb(2, 0)), 1);

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_done", int'(done_o[0]), 0);
        check("reset_pass", int'(pass_o[1]), 0);
        idle($urandom_range(1, 5));

        run_k(0, 0, nc, ne);
        check("t1_done_cycle", nc, 13);
        check("t1_pass", int'(pass_o[0]), 4);
        check("t1_fail", int'(fail_o[0]), 0);
        check("t1_err", ne, 0);
        idle($urandom_range(1, 5));

        run_k(0, 1, nc, ne);
        check("t2_pass", int'(pass_o[0]), 3);
        check("t2_fail", int'(fail_o[0]), 1);
        check("t2_ffa", int'(ffa_o[0]), 0);
        check("t2_ffb", int'(ffb_o[0]), 1);
        check("t2_err_pulses", ne, 1);
        check("t2_fail_seen", int'(fs_o[0]), 1);

        run_k(0, 2, nc, ne);
        check("t5_fail", int'(fail_o[0]), 4);
        check("t5_pass", int'(pass_o[0]), 0);
        check("t5_ffa", int'(ffa_o[0]), 0);
        check("t5_err_pulses", ne, 4);

        fault[0] = 0;
        start[0] = 1'b1;
        idle(1);
        start[0] = 1'b0;
        idle(4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_busy", int'(busy_o[0]), 0);
        check("t6_pass", int'(pass_o[0]), 0);
        check("t6_a", int'(a_o[0]), 0);
        idle(2);
        run_k(0, 0, nc, ne);
        check("t6_rerun_pass", int'(pass_o[0]), 4);

        run_k(1, 0, nc, ne);
        check("t3_done_cycle", nc, 513);
        check("t3_pass", int'(pass_o[1]), 256);
        key[1] = 16'($urandom_range(0, 255));
        run_k(1, 3, nc, ne);
        check("rk_fail", int'(fail_o[1]), 1);
        check("rk_ffa", int'(ffa_o[1]), int'(key[1][7:4]));
        check("rk_ffb", int'(ffb_o[1]), int'(key[1][3:0]));

        run_k(2, 0, nc, ne);
        check("t4_done_cycle", nc, 65);
        check("t4_pass", int'(pass_o[2]), 16);
        key[2] = lfsr_tab[$urandom_range(0, 15)] & 16'h000F;
        cnt = 0;
        for (int i = 0; i < 16; i++) if ((lfsr_tab[i] & 16'h000F) == key[2]) cnt++;
        run_k(2, 3, nc, ne);
        check("r2_fail", int'(fail_o[2]), cnt);
        check("r2_err_pulses", ne, cnt);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
